// File: rtl/mem_rd_port_arbiter_pkg.sv
// Shared types and constants for the memory read-port arbiter slice.
// Holds the arbiter state encoding, the requester-count ceiling and the rotate helper.
package mem_arb_pkg;

   localparam int unsigned MEM_ARB_MAX_REQ = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_HOLD
   } ARB_STATE;

   // Requester index visited at a given step of the rotating scan after 'last'.
   function automatic int unsigned rr_index(input int unsigned last,
                                            input int unsigned step,
                                            input int unsigned n);
      return (last + step) % n;
   endfunction

endpackage

// File: rtl/mem_rd_port_arbiter_rr_picker.sv
// Combinational round-robin picker: scans requesters starting just after the
// last granted one and reports the first active request.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic                     any,
   output logic [$clog2(N_REQ)-1:0] winner
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   logic        found;
   int unsigned idx;

   assign any = |req;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned i = 1; i <= MEM_ARB_MAX_REQ; i++) begin
         if (i <= N_REQ) begin
            idx = rr_index(32'(last), i, N_REQ);
            if (!found && req[IDX_W'(idx)]) begin
               found  = 1'b1;
               winner = IDX_W'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/mem_rd_port_arbiter.sv
// Round-robin arbiter sharing one memory read port between N_REQ requesters,
// one outstanding read, registered response route-back and per-read timeout.
module mem_rd_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 2,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_REQ-1:0][ADDR_W-1:0]   req_rd_addr,
   input  logic [N_REQ-1:0]               req_rd_addr_valid,
   output logic [DATA_W-1:0]              req_rd_data,
   output logic [N_REQ-1:0]               req_rd_ack,
   output logic [N_REQ-1:0]               req_rd_err,
   output logic [ADDR_W-1:0]              mem_rd_addr,
   output logic                           mem_rd_addr_valid,
   input  logic [DATA_W-1:0]              mem_rd_data,
   input  logic                           mem_rd_ack,
   output logic [$clog2(N_REQ)-1:0]       grant_id,
   output logic                           busy
);

   localparam int unsigned GNT_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);

   ARB_STATE            state_q, state_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [GNT_W-1:0]    last_grant_q, last_grant_d;
   logic [GNT_W-1:0]    grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                addr_valid_q, addr_valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [N_REQ-1:0]    err_q, err_d;

   logic                pick_any;
   logic [GNT_W-1:0]    pick_winner;

   rr_picker #(
      .N_REQ(N_REQ)
   ) u_picker (
      .req   (req_rd_addr_valid),
      .last  (last_grant_q),
      .any   (pick_any),
      .winner(pick_winner)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      addr_valid_d = addr_valid_q;
      data_d       = data_q;
      ack_d        = '0;
      err_d        = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               addr_d       = req_rd_addr[pick_winner];
               addr_valid_d = 1'b1;
               grant_d      = pick_winner;
               wait_cnt_d   = '0;
               state_d      = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            // Ack is tested first so a completion on the limit cycle is never aborted.
            if (mem_rd_ack) begin
               addr_valid_d   = 1'b0;
               data_d         = mem_rd_data;
               ack_d[grant_q] = 1'b1;
               last_grant_d   = grant_q;
               state_d        = ARB_HOLD;
            end else if ((MAX_WAIT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
               addr_valid_d   = 1'b0;
               err_d[grant_q] = 1'b1;
               last_grant_d   = grant_q;
               state_d        = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         wait_cnt_q   <= '0;
         last_grant_q <= GNT_W'(N_REQ - 1);
         grant_q      <= '0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         data_q       <= '0;
         ack_q        <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         data_q       <= data_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
      end
   end

   assign req_rd_data       = data_q;
   assign req_rd_ack        = ack_q;
   assign req_rd_err        = err_q;
   assign mem_rd_addr       = addr_q;
   assign mem_rd_addr_valid = addr_valid_q;
   assign grant_id          = grant_q;
   assign busy              = (state_q != ARB_IDLE);

endmodule
